// File: rtl/fifo_pkg.sv
// Shared defaults for the synchronous FIFO: word width, depth and pointer width.
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;
  localparam int PTR_W      = $clog2(DEF_DEPTH);

endpackage

// File: rtl/fifo_if.sv
// Signal bundle for the FIFO, shared by the bench environment; clock is driven by the bench.
interface fifo_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic              clock;
  logic              wr;
  logic              rd;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              rst;
endinterface

// File: rtl/fifo_mem.sv
// FIFO storage: register array with synchronous write and combinational read mux.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are intentionally not reset; pointers make stale words unreachable.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo.sv
// Single-clock FIFO: pointers, occupancy counter, flags and the registered read port.
module fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clock,
  input  logic              wr,
  input  logic              rd,
  output logic              full,
  output logic              empty,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic              rst
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] rd_data;
  logic              do_wr;
  logic              do_rd;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign do_wr = wr & ~full;
  assign do_rd = rd & ~empty;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clock (clock),
    .we    (do_wr),
    .waddr (wptr),
    .wdata (data_in),
    .raddr (rptr),
    .rdata (rd_data)
  );

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      data_out <= '0;
    end else begin
      if (do_wr) begin
        wptr <= wptr + AW'(1);
      end
      if (do_rd) begin
        rptr     <= rptr + AW'(1);
        data_out <= rd_data;
      end
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo.sv
// Directed self-checking bench for fifo: reset, fill/drain, wrap, simultaneous access, async reset.
module tb_fifo;
  import fifo_pkg::*;

  fifo_if #(.DATA_W(DEF_DATA_W)) bus ();

  int n_checks = 0;
  int n_errors = 0;

  fifo #(.DATA_W(DEF_DATA_W), .DEPTH(DEF_DEPTH)) u_dut (
    .clock    (bus.clock),
    .wr       (bus.wr),
    .rd       (bus.rd),
    .full     (bus.full),
    .empty    (bus.empty),
    .data_in  (bus.data_in),
    .data_out (bus.data_out),
    .rst      (bus.rst)
  );

  initial bus.clock = 1'b0;
  always #5 bus.clock = ~bus.clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, then return 1 time unit after the rising edge.
  task automatic cycle(input logic w, input logic r, input logic [7:0] d);
    bus.wr      = w;
    bus.rd      = r;
    bus.data_in = d;
    @(posedge bus.clock);
    #1;
    bus.wr = 1'b0;
    bus.rd = 1'b0;
  endtask

  initial begin
    bus.rst     = 1'b0;
    bus.wr      = 1'b0;
    bus.rd      = 1'b0;
    bus.data_in = '0;

    // Reset
    repeat (3) @(posedge bus.clock);
    #3;
    check_val("rst_empty", 32'(bus.empty), 32'd1);
    check_val("rst_full", 32'(bus.full), 32'd0);
    check_val("rst_dout", 32'(bus.data_out), 32'h00);
    bus.rst = 1'b1;
    cycle(1'b0, 1'b0, 8'h00);
    check_val("post_rst_empty", 32'(bus.empty), 32'd1);
    check_val("post_rst_dout", 32'(bus.data_out), 32'h00);

    // Fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 1'b0, 8'(i));
      if (i == 1) check_val("fill_empty_fall", 32'(bus.empty), 32'd0);
      check_val("fill_full", 32'(bus.full), (i == 16) ? 32'd1 : 32'd0);
    end
    cycle(1'b1, 1'b0, 8'hFF);
    check_val("ovf_full", 32'(bus.full), 32'd1);
    check_val("ovf_cnt", 32'(u_dut.cnt), 32'd16);
    check_val("ovf_dout", 32'(bus.data_out), 32'h00);

    // Drain
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      check_val("drain_dout", 32'(bus.data_out), 32'(i));
      check_val("drain_empty", 32'(bus.empty), (i == 16) ? 32'd1 : 32'd0);
      if (i == 1) check_val("drain_full_fall", 32'(bus.full), 32'd0);
    end
    cycle(1'b0, 1'b1, 8'h00);
    check_val("udf_dout", 32'(bus.data_out), 32'h10);
    check_val("udf_cnt", 32'(u_dut.cnt), 32'd0);

    // Wrap-around
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'(8'h50 + i));
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      check_val("wrap1_dout", 32'(bus.data_out), 32'(8'h50 + i));
    end
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'(8'hA0 + i));
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      check_val("wrap2_dout", 32'(bus.data_out), 32'(8'hA0 + i));
    end
    check_val("wrap_empty", 32'(bus.empty), 32'd1);

    // wr & rd while empty: write only
    cycle(1'b1, 1'b1, 8'h77);
    check_val("sim_empty_dout", 32'(bus.data_out), 32'hA9);
    check_val("sim_empty_empty", 32'(bus.empty), 32'd0);
    check_val("sim_empty_cnt", 32'(u_dut.cnt), 32'd1);

    // wr & rd with 3 stored
    cycle(1'b1, 1'b0, 8'h78);
    cycle(1'b1, 1'b0, 8'h79);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 8'(8'h80 + i));
      check_val("sim_dout", 32'(bus.data_out), (i < 3) ? 32'(8'h77 + i) : 32'(8'h80 + i - 3));
      check_val("sim_cnt", 32'(u_dut.cnt), 32'd3);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      check_val("sim_tail_dout", 32'(bus.data_out), 32'(8'h82 + i));
    end
    check_val("sim_tail_empty", 32'(bus.empty), 32'd1);

    // wr & rd while full: read only, write dropped
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(8'hC0 + i));
    check_val("full2_full", 32'(bus.full), 32'd1);
    cycle(1'b1, 1'b1, 8'hEE);
    check_val("simfull_dout", 32'(bus.data_out), 32'hC0);
    check_val("simfull_cnt", 32'(u_dut.cnt), 32'd15);
    for (int i = 1; i < 16; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      check_val("simfull_drain", 32'(bus.data_out), 32'(8'hC0 + i));
    end
    check_val("simfull_empty", 32'(bus.empty), 32'd1);

    // Async reset with 5 entries stored
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'h30 + i));
    cycle(1'b0, 1'b1, 8'h00);
    check_val("pre_arst_dout", 32'(bus.data_out), 32'h30);
    #2;
    bus.rst = 1'b0;
    #1;
    check_val("arst_empty", 32'(bus.empty), 32'd1);
    check_val("arst_full", 32'(bus.full), 32'd0);
    check_val("arst_dout", 32'(bus.data_out), 32'h00);
    check_val("arst_cnt", 32'(u_dut.cnt), 32'd0);
    #3;
    bus.rst = 1'b1;
    cycle(1'b0, 1'b1, 8'h00);
    check_val("after_arst_dout", 32'(bus.data_out), 32'h00);
    check_val("after_arst_empty", 32'(bus.empty), 32'd1);
    cycle(1'b1, 1'b0, 8'h5A);
    cycle(1'b0, 1'b1, 8'h00);
    check_val("after_arst_rw", 32'(bus.data_out), 32'h5A);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
